// File: rtl/clint_timer_ctrl.sv
// clint_timer_ctrl: CLINT-style machine timer and software interrupt controller with a valid/ready register port
//   clk, rst                : clock, synchronous active-high reset
//   req_*                   : single-outstanding register request (byte address, wdata, wstrb)
//   rsp_*                   : response held until rsp_ready (rdata, err for unmapped address)
//   mtime                   : free-running prescaled 64-bit time to the core
//   m_interrupt_timer       : registered level, mtime >= mtimecmp
//   m_interrupt_software    : level, msip bit
module clint_timer_ctrl #(
    parameter int PRESCALE = 1,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [63:0]       mtime,
    output logic              m_interrupt_timer,
    output logic              m_interrupt_software
);
    typedef enum logic {IDLE, RESP} state_t;
    localparam logic [15:0]       P_LAST   = 16'(PRESCALE - 1);
    localparam logic [ADDR_W-1:0] A_MSIP   = ADDR_W'('h0000);
    localparam logic [ADDR_W-1:0] A_CMP_LO = ADDR_W'('h4000);
    localparam logic [ADDR_W-1:0] A_CMP_HI = ADDR_W'('h4004);
    localparam logic [ADDR_W-1:0] A_MT_LO  = ADDR_W'('hBFF8);
    localparam logic [ADDR_W-1:0] A_MT_HI  = ADDR_W'('hBFFC);
    state_t            state;
    logic [15:0]       pcnt;
    logic              tick;
    logic [63:0]       mtimecmp;
    logic              msip;
    logic [ADDR_W-1:0] word_addr;
    logic              hit_msip, hit_cmp_lo, hit_cmp_hi, hit_mt_lo, hit_mt_hi, mapped;
    logic              accept, wr;
    logic [31:0]       rd_data;
    logic              unused_addr;
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction
    // With PRESCALE = 1 the count sits at 0 == P_LAST, so tick is constantly high
    assign tick        = pcnt == P_LAST;
    assign word_addr   = {req_addr[ADDR_W-1:2], 2'b00};
    assign unused_addr = ^req_addr[1:0];
    assign hit_msip    = word_addr == A_MSIP;
    assign hit_cmp_lo  = word_addr == A_CMP_LO;
    assign hit_cmp_hi  = word_addr == A_CMP_HI;
    assign hit_mt_lo   = word_addr == A_MT_LO;
    assign hit_mt_hi   = word_addr == A_MT_HI;
    assign mapped      = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_mt_lo | hit_mt_hi;
    assign accept      = req_valid && state == IDLE;
    assign wr          = accept && req_we && mapped;
    assign m_interrupt_software = msip;
    always_comb begin
        rd_data = hit_msip   ? {31'b0, msip} :
                  hit_cmp_lo ? mtimecmp[31:0] :
                  hit_cmp_hi ? mtimecmp[63:32] :
                  hit_mt_lo  ? mtime[31:0] :
                  hit_mt_hi  ? mtime[63:32] : 32'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            pcnt              <= '0;
            mtime             <= '0;
            mtimecmp          <= '1;
            msip              <= 1'b0;
            m_interrupt_timer <= 1'b0;
            req_ready         <= 1'b1;
            rsp_valid         <= 1'b0;
            rsp_rdata         <= '0;
            rsp_err           <= 1'b0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 16'd1;
            // A write to either mtime half wins over the tick and suppresses the whole increment
            if (wr && hit_mt_lo)
                mtime[31:0] <= merge(mtime[31:0], req_wdata, req_wstrb);
            else if (wr && hit_mt_hi)
                mtime[63:32] <= merge(mtime[63:32], req_wdata, req_wstrb);
            else if (tick)
                mtime <= mtime + 64'd1;
            if (wr && hit_cmp_lo)
                mtimecmp[31:0] <= merge(mtimecmp[31:0], req_wdata, req_wstrb);
            if (wr && hit_cmp_hi)
                mtimecmp[63:32] <= merge(mtimecmp[63:32], req_wdata, req_wstrb);
            if (wr && hit_msip && req_wstrb[0])
                msip <= req_wdata[0];
            m_interrupt_timer <= mtime >= mtimecmp;
            case (state)
                IDLE: if (req_valid) begin
                    state     <= RESP;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= (mapped && !req_we) ? rd_data : 32'b0;
                    rsp_err   <= !mapped;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clint_timer_ctrl.sv
// tb_clint_timer_ctrl: randomized and directed checks of clint_timer_ctrl against an arithmetic time/register model
module tb_clint_timer_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] mtime;
    logic        irq_t, irq_s;
    logic        p4_req_ready, p4_rsp_valid, p4_rsp_err, p4_irq_t, p4_irq_s;
    logic [31:0] p4_rsp_rdata;
    logic [63:0] p4_mtime;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          c_r = 0;
    logic [63:0] mt_base = '0;
    int          mt_edge = 0;
    logic [63:0] cmp_m = '1;
    logic        msip_m = 1'b0;
    logic        irq_acc;

    clint_timer_ctrl #(.PRESCALE(1), .ADDR_W(16)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mtime(mtime),
        .m_interrupt_timer(irq_t), .m_interrupt_software(irq_s)
    );

    clint_timer_ctrl #(.PRESCALE(4), .ADDR_W(16)) u_p4 (
        .clk(clk), .rst(rst), .req_valid(1'b0), .req_ready(p4_req_ready), .req_we(1'b0),
        .req_addr(16'h0000), .req_wdata(32'h0), .req_wstrb(4'h0), .rsp_valid(p4_rsp_valid),
        .rsp_ready(1'b1), .rsp_rdata(p4_rsp_rdata), .rsp_err(p4_rsp_err), .mtime(p4_mtime),
        .m_interrupt_timer(p4_irq_t), .m_interrupt_software(p4_irq_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    // Expected mtime right after edge c: with PRESCALE = 1 every edge since the last write adds one
    function automatic logic [63:0] mt_at(input int c);
        return mt_base + 64'(c - mt_edge);
    endfunction

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic xact(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output logic er);
        logic        acc, rdy, exp_err;
        logic [31:0] exp_rd;
        logic [63:0] pre;
        int          k;
        acc = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        for (int t = 0; t < 10 && !acc; t++) begin
            rdy = req_ready;
            @(posedge clk); #1;
            acc = rdy;
        end
        req_valid = 1'b0;
        rd = rsp_rdata; er = rsp_err;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL accept_timeout addr=%h got=not_accepted want=accepted", addr);
            return;
        end
        k = cyc;
        irq_acc = irq_t;
        pre = mt_at(k - 1);
        exp_err = 1'b0; exp_rd = 32'h0;
        case (addr & 16'hFFFC)
            16'h0000: begin exp_rd = {31'b0, msip_m}; if (we && ws[0]) msip_m = wd[0]; end
            16'h4000: begin exp_rd = cmp_m[31:0];  if (we) cmp_m[31:0]  = bmerge(cmp_m[31:0], wd, ws); end
            16'h4004: begin exp_rd = cmp_m[63:32]; if (we) cmp_m[63:32] = bmerge(cmp_m[63:32], wd, ws); end
            16'hBFF8: begin exp_rd = pre[31:0];
                if (we) begin mt_base = {pre[63:32], bmerge(pre[31:0], wd, ws)}; mt_edge = k; end end
            16'hBFFC: begin exp_rd = pre[63:32];
                if (we) begin mt_base = {bmerge(pre[63:32], wd, ws), pre[31:0]}; mt_edge = k; end end
            default: exp_err = 1'b1;
        endcase
        if (we) exp_rd = 32'h0;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rsp_valid addr=%h got=%b want=1", addr, rsp_valid); end
        checks++;
        if (rd !== exp_rd) begin failures++; $display("FAIL rsp_rdata addr=%h we=%b got=%h want=%h", addr, we, rd, exp_rd); end
        checks++;
        if (er !== exp_err) begin failures++; $display("FAIL rsp_err addr=%h got=%b want=%b", addr, er, exp_err); end
        checks++;
        if (mtime !== mt_at(k)) begin failures++; $display("FAIL mtime_after_accept addr=%h got=%h want=%h", addr, mtime, mt_at(k)); end
        checks++;
        if (irq_s !== msip_m) begin failures++; $display("FAIL sw_irq addr=%h got=%b want=%b", addr, irq_s, msip_m); end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            begin failures++; $display("FAIL rsp_release got=valid%b_ready%b want=valid0_ready1", rsp_valid, req_ready); end
    endtask

    task automatic watch(input int n);
        logic exp_irq;
        for (int i = 0; i < n; i++) begin
            exp_irq = mt_at(cyc) >= cmp_m;
            @(posedge clk); #1;
            checks++;
            if (mtime !== mt_at(cyc)) begin failures++; $display("FAIL watch_mtime got=%h want=%h", mtime, mt_at(cyc)); end
            checks++;
            if (irq_t !== exp_irq) begin failures++; $display("FAIL watch_timer_irq mtime=%h got=%b want=%b", mtime, irq_t, exp_irq); end
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic        er;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        c_r = cyc;
        checks++;
        if (mtime !== 64'h0 || p4_mtime !== 64'h0) begin failures++; $display("FAIL reset_mtime got=%h/%h want=0", mtime, p4_mtime); end
        checks++;
        if (irq_t !== 1'b0 || irq_s !== 1'b0) begin failures++; $display("FAIL reset_irqs got=%b%b want=00", irq_t, irq_s); end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_handshake got=ready%b_valid%b want=ready1_valid0", req_ready, rsp_valid); end
        rst = 1'b0;
        mt_base = '0; mt_edge = c_r; cmp_m = '1; msip_m = 1'b0;
    endtask

    task automatic test_prescale;
        int j;
        for (int t = 0; t < 100 && (cyc - c_r) < 40; t++) begin
            @(posedge clk); #1;
            j = cyc - c_r;
            checks++;
            if (p4_mtime !== 64'(j / 4)) begin failures++; $display("FAIL prescale_step edge=%0d got=%0d want=%0d", j, p4_mtime, j / 4); end
        end
        checks++;
        if (p4_mtime !== 64'd10) begin failures++; $display("FAIL prescale_40 got=%0d want=10", p4_mtime); end
    endtask

    task automatic test_reset_read;
        logic [31:0] rd;
        logic        er;
        xact(1'b0, 16'h4004, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'hFFFF_FFFF || er !== 1'b0) begin failures++; $display("FAIL reset_cmp_hi got=%h/%b want=ffffffff/0", rd, er); end
    endtask

    task automatic test_timer_irq;
        logic [31:0] rd;
        logic        er;
        xact(1'b1, 16'hBFFC, 32'h0, 4'hF, rd, er);
        xact(1'b1, 16'hBFF8, 32'h0, 4'hF, rd, er);
        xact(1'b1, 16'h4004, 32'h0, 4'hF, rd, er);
        xact(1'b1, 16'h4000, 32'd20, 4'hF, rd, er);
        watch(30);
        checks++;
        if (irq_t !== 1'b1) begin failures++; $display("FAIL timer_irq_high got=%b want=1", irq_t); end
        xact(1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF, rd, er);
        checks++;
        if (irq_acc !== 1'b1) begin failures++; $display("FAIL timer_irq_at_accept got=%b want=1", irq_acc); end
        checks++;
        if (irq_t !== 1'b0) begin failures++; $display("FAIL timer_irq_fall got=%b want=0", irq_t); end
        watch(4);
    endtask

    task automatic test_sw_irq;
        logic [31:0] rd;
        logic        er;
        xact(1'b1, 16'h0000, 32'h1, 4'b0000, rd, er);
        checks++;
        if (irq_s !== 1'b0) begin failures++; $display("FAIL sw_wstrb0 got=%b want=0", irq_s); end
        xact(1'b1, 16'h0000, 32'h1, 4'b0001, rd, er);
        checks++;
        if (irq_s !== 1'b1) begin failures++; $display("FAIL sw_set got=%b want=1", irq_s); end
        xact(1'b0, 16'h0000, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h1) begin failures++; $display("FAIL sw_read got=%h want=00000001", rd); end
    endtask

    task automatic test_wrap_collision;
        logic [31:0] rd;
        logic        er;
        xact(1'b1, 16'hBFF8, 32'h0, 4'hF, rd, er);
        xact(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, rd, er);
        xact(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, rd, er);
        @(posedge clk); #1;
        checks++;
        if (mtime !== 64'h0 || er !== 1'b0) begin failures++; $display("FAIL wrap got=%h/%b want=0/0", mtime, er); end
        xact(1'b1, 16'hBFF8, 32'd5, 4'hF, rd, er);
        checks++;
        if (mtime[63:32] !== 32'h0 || mtime[31:0] !== 32'd6) begin failures++; $display("FAIL collision got=%h want=6_after_release", mtime); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic        er;
        xact(1'b0, 16'h1234, 32'h0, 4'h0, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL unmapped got=%h/%b want=0/1", rd, er); end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4000;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_addr = 16'h4004;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== cmp_m[31:0] || req_ready !== 1'b0)
                begin failures++; $display("FAIL hold cyc=%0d got=v%b_d%h_r%b want=v1_d%h_r0", i, rsp_valid, rsp_rdata, req_ready, cmp_m[31:0]); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL release got=v%b_r%b want=v0_r1", rsp_valid, req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== cmp_m[63:32]) begin failures++; $display("FAIL second_req got=v%b_d%h want=v1_d%h", rsp_valid, rsp_rdata, cmp_m[63:32]); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [31:0] rd;
        logic        er;
        logic [15:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: a = 16'h0000;
                1: a = 16'h4000;
                2: a = 16'h4004;
                3: a = 16'hBFF8;
                4: a = 16'hBFFC;
                default: a = 16'($urandom);
            endcase
            a = a | 16'($urandom_range(0, 3));
            xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd, er);
        end
        watch(8);
    endtask

    initial begin
        test_reset;
        test_prescale;
        test_reset_read;
        test_timer_irq;
        test_sw_irq;
        test_wrap_collision;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
